// File: rtl/fifo_rd_serializer.sv
// Drains a wide clock-crossing FIFO and streams each word out as
// fixed-width beats, LSB beat first, on a valid/ready interface.
module fifo_rd_serializer #(
    parameter int DSIZE  = 140,
    parameter int OSIZE  = 14,
    parameter int RD_LAT = 0
) (
    input  logic             clk_out,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [DSIZE-1:0] data_from_fifo,
    output logic             fifo_r_enable,
    output logic [OSIZE-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int NBEAT = DSIZE / OSIZE;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BW-1:0] LAST = BW'(NBEAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state, state_n;
    logic [NBEAT-1:0][OSIZE-1:0] word, word_n;
    logic [BW-1:0] beat, beat_n;
    logic [15:0] cnt, cnt_n;
    logic pop;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            beat  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            word  <= word_n;
            beat  <= beat_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        word_n  = word;
        beat_n  = beat;
        cnt_n   = cnt;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (RD_LAT == 0) begin
                        word_n  = data_from_fifo;
                        beat_n  = '0;
                        state_n = SEND;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                word_n  = data_from_fifo;
                beat_n  = '0;
                state_n = SEND;
            end
            SEND: begin
                if (dout_ready) begin
                    if (beat == LAST) begin
                        cnt_n  = cnt + 16'd1;
                        beat_n = '0;
                        // Refill on the closing handshake to avoid a bubble
                        if (!fifo_empty) begin
                            pop = 1'b1;
                            if (RD_LAT == 0) begin
                                word_n = data_from_fifo;
                            end else begin
                                state_n = WAIT;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fifo_r_enable = pop;
    assign dout_valid    = (state == SEND);
    assign dout          = dout_valid ? word[beat] : '0;
    assign dout_last     = dout_valid && (beat == LAST);
    assign busy          = (state != IDLE);
    assign word_cnt      = cnt;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench: show-ahead and registered-read FIFO models drive
// two serializer instances; checks beats, pops, counters and reset.
module tb_fifo_rd_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [139:0] mem0 [0:31];
    logic [139:0] mem1 [0:31];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    int npop0 = 0, npop1 = 0;
    int nassert = 0, nfail = 0;

    logic         empty0, empty1, pop0, pop1;
    logic         valid0, valid1, last0, last1, busy0, busy1;
    logic         ready0 = 1'b1, ready1 = 1'b1;
    logic [139:0] data0, data1;
    logic [13:0]  dout0, dout1;
    logic [15:0]  wcnt0, wcnt1;

    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);
    assign data0  = mem0[rp0];

    always @(posedge clk) begin
        if (pop0) begin
            rp0 <= rp0 + 1;
            npop0 <= npop0 + 1;
        end
        if (pop1) begin
            data1 <= mem1[rp1];
            rp1 <= rp1 + 1;
            npop1 <= npop1 + 1;
        end
    end

    fifo_rd_serializer #(.DSIZE(140), .OSIZE(14), .RD_LAT(0)) u0 (
        .clk_out(clk), .rst_n(rst_n), .fifo_empty(empty0),
        .data_from_fifo(data0), .fifo_r_enable(pop0), .dout(dout0),
        .dout_valid(valid0), .dout_ready(ready0), .dout_last(last0),
        .busy(busy0), .word_cnt(wcnt0)
    );

    fifo_rd_serializer #(.DSIZE(140), .OSIZE(14), .RD_LAT(1)) u1 (
        .clk_out(clk), .rst_n(rst_n), .fifo_empty(empty1),
        .data_from_fifo(data1), .fifo_r_enable(pop1), .dout(dout1),
        .dout_valid(valid1), .dout_ready(ready1), .dout_last(last1),
        .busy(busy1), .word_cnt(wcnt1)
    );

    function automatic logic [139:0] mk(input int base);
        logic [139:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) w[i*14 +: 14] = 14'(base + i);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input int base);
        mem0[wp0] = mk(base);
        wp0++;
    endtask

    task automatic push1(input int base);
        mem1[wp1] = mk(base);
        wp1++;
    endtask

    logic [31:0] pat = 32'b1011_0010_0110_1101_0011_0100_1110_0101;
    int idx;
    int bases [0:2];

    initial begin
        bases[0] = 'h100; bases[1] = 'h200; bases[2] = 'h300;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_out0", {dout0, valid0, last0, busy0, pop0}, 0);
        chk("rst_out1", {dout1, valid1, last1, busy1, pop1}, 0);
        chk("rst_cnt", {wcnt0, wcnt1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_empty", {busy0, pop0, busy1, pop1}, 0);

        // single word, show-ahead
        @(negedge clk);
        push0(1);
        #1;
        chk("single_pop", {pop0, valid0}, 2'b10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("single_beat", {valid0, last0, dout0},
                {1'b1, i == 9, 14'(1 + i)});
            chk("single_nopop", pop0, 0);
        end
        @(negedge clk); #1;
        chk("single_end", {busy0, valid0}, 0);
        chk("single_cnt", wcnt0, 1);
        chk("single_npop", npop0, 1);

        // three words back to back, show-ahead
        @(negedge clk);
        for (int w = 0; w < 3; w++) push0(bases[w]);
        #1;
        chk("b2b_pop0", pop0, 1);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); #1;
                chk("b2b_beat", {valid0, last0, dout0},
                    {1'b1, i == 9, 14'(bases[w] + i)});
                chk("b2b_pop", pop0, (i == 9 && w < 2) ? 1 : 0);
            end
        end
        @(negedge clk); #1;
        chk("b2b_idle", busy0, 0);
        chk("b2b_cnt", wcnt0, 4);
        chk("b2b_npop", npop0, 4);

        // same three words, registered read
        @(negedge clk);
        for (int w = 0; w < 3; w++) push1(bases[w]);
        #1;
        chk("lat1_pop0", pop1, 1);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk); #1;
            chk("lat1_wait", {valid1, busy1, pop1}, 3'b010);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); #1;
                chk("lat1_beat", {valid1, last1, dout1},
                    {1'b1, i == 9, 14'(bases[w] + i)});
                chk("lat1_pop", pop1, (i == 9 && w < 2) ? 1 : 0);
            end
        end
        @(negedge clk); #1;
        chk("lat1_idle", busy1, 0);
        chk("lat1_cnt", wcnt1, 3);
        chk("lat1_npop", npop1, 3);

        // backpressure with a fixed ready pattern, two words queued
        @(negedge clk);
        push0('h400);
        push0('h500);
        ready0 = 1'b0;
        idx = 0;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            @(negedge clk);
            ready0 = pat[c % 32];
            #1;
            chk("bp_beat", {valid0, last0, dout0},
                {1'b1, (idx % 10) == 9,
                 14'((idx < 10 ? 'h400 : 'h500) + idx % 10)});
            chk("bp_pop", pop0,
                (ready0 && (idx == 9)) ? 1 : 0);
            if (ready0) idx++;
        end
        chk("bp_done", idx, 20);
        ready0 = 1'b1;
        @(negedge clk); #1;
        chk("bp_idle", busy0, 0);
        chk("bp_cnt", wcnt0, 6);

        // empty at last handshake, refill one cycle later
        @(negedge clk);
        push0('h600);
        #1;
        chk("eb_pop0", pop0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("eb_beat", {valid0, last0, dout0},
                {1'b1, i == 9, 14'('h600 + i)});
            chk("eb_nopop", pop0, 0);
        end
        @(negedge clk);
        #1;
        chk("eb_idle", {busy0, valid0, pop0}, 0);
        push0('h700);
        #1;
        chk("eb_refill_pop", pop0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("eb_beat2", {valid0, last0, dout0},
                {1'b1, i == 9, 14'('h700 + i)});
        end
        @(negedge clk); #1;
        chk("eb_cnt", wcnt0, 8);

        // asynchronous reset in the middle of a word
        @(negedge clk);
        push0('h800);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
        end
        chk("mid_beat4", {valid0, dout0}, {1'b1, 14'h804});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {dout0, valid0, last0, busy0, pop0}, 0);
        chk("mid_rst_cnt", {wcnt0, wcnt1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("post_rst_idle", {busy0, pop0, valid0}, 0);
        end
        chk("no_refetch", npop0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
